vga_fill_arbiter: RTL and testbench

Shares the single framebuffer write port of the VGA controller (`vga_wren_enable` / `vga_data_addr` / `vga_data_write`) between the processor and a hardware rectangle-fill engine. It sits between `processor` and `vga_abstract` in `skeleton`. The processor's pixel writes and engine-generated fills are arbitrated round-robin, with a stall back to the processor. The engine fills a clipped axis-aligned rectangle with one colour, one pixel per granted cycle, in row-major order.

---
 rtl/vga_fill_arbiter.sv | 152 +++++++++++++++
 tb/tb_vga_fill_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fill_arbiter.sv
// rtl/vga_fill_arbiter.sv - framebuffer write-port arbiter between the processor and a rectangle-fill engine
// Round-robin arbitration of CPU pixel writes and row-major fill writes, registered onto the VGA port.
module vga_fill_arbiter #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 24
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_stall,
  input  logic              fill_start,
  input  logic [9:0]        fill_x0,
  input  logic [8:0]        fill_y0,
  input  logic [9:0]        fill_w,
  input  logic [8:0]        fill_h,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              vga_wren_enable,
  output logic [ADDR_W-1:0] vga_data_addr,
  output logic [DATA_W-1:0] vga_data_write
);

  localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(H_RES * V_RES);

  typedef enum logic [1:0] {IDLE, CLIP, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [9:0]          x0_q, w_q, x_q;
  logic [8:0]          y0_q, h_q, y_q;
  logic [DATA_W-1:0]   color_q;
  logic [10:0]         x_end_q;
  logic [9:0]          y_end_q;
  logic [ADDR_W-1:0]   row_base;
  logic                prio;

  logic [10:0]         x_sum, x_end_c, x_inc;
  logic [9:0]          y_sum, y_end_c, y_inc;
  logic                empty, row_last, col_last;
  logic                fill_req, fill_gnt, cpu_gnt, cpu_valid;
  logic [ADDR_W-1:0]   fill_addr;

  // Sums are one bit wider than the operands so the clip compare never wraps.
  assign x_sum    = {1'b0, x0_q} + {1'b0, w_q};
  assign y_sum    = {1'b0, y0_q} + {1'b0, h_q};
  assign x_end_c  = (x_sum > 11'(H_RES)) ? 11'(H_RES) : x_sum;
  assign y_end_c  = (y_sum > 10'(V_RES)) ? 10'(V_RES) : y_sum;
  assign empty    = (w_q == '0) || (h_q == '0) ||
                    ({1'b0, x0_q} >= 11'(H_RES)) || ({1'b0, y0_q} >= 10'(V_RES));
  assign x_inc    = {1'b0, x_q} + 11'd1;
  assign y_inc    = {1'b0, y_q} + 10'd1;
  assign row_last = (x_inc == x_end_q);
  assign col_last = (y_inc == y_end_q);
  assign fill_addr = row_base + ADDR_W'(x_q);

  assign fill_gnt  = fill_req & (~cpu_wren | prio);
  assign cpu_gnt   = cpu_wren & ~(fill_req & prio);
  assign cpu_stall = cpu_wren & fill_req & prio;
  assign cpu_valid = (cpu_addr < FB_SIZE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (fill_start) state_nxt = CLIP;
      CLIP: state_nxt = empty ? DONE : RUN;
      RUN:  if (fill_gnt && row_last && col_last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fill_req  = 1'b0;
    fill_busy = 1'b0;
    fill_done = 1'b0;
    fill_req  = (state == RUN);
    fill_busy = (state != IDLE);
    fill_done = (state == DONE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      color_q  <= '0;
      x_end_q  <= '0;
      y_end_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      row_base <= '0;
    end else begin
      case (state)
        IDLE: if (fill_start) begin
          x0_q    <= fill_x0;
          y0_q    <= fill_y0;
          w_q     <= fill_w;
          h_q     <= fill_h;
          color_q <= fill_color;
        end
        CLIP: begin
          x_end_q  <= x_end_c;
          y_end_q  <= y_end_c;
          x_q      <= x0_q;
          y_q      <= y0_q;
          row_base <= ADDR_W'(y0_q) * ADDR_W'(H_RES);
        end
        RUN: if (fill_gnt) begin
          if (row_last) begin
            x_q      <= x0_q;
            y_q      <= y_q + 9'd1;
            row_base <= row_base + ADDR_W'(H_RES);
          end else begin
            x_q <= x_q + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Out-of-range CPU writes are still accepted; they just never strobe the port.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prio            <= 1'b0;
      vga_wren_enable <= 1'b0;
      vga_data_addr   <= '0;
      vga_data_write  <= '0;
    end else begin
      if (cpu_wren && fill_req) prio <= ~prio;
      vga_wren_enable <= fill_gnt | (cpu_gnt & cpu_valid);
      if (fill_gnt) begin
        vga_data_addr  <= fill_addr;
        vga_data_write <= color_q;
      end else if (cpu_gnt) begin
        vga_data_addr  <= cpu_addr;
        vga_data_write <= cpu_data;
      end
    end
  end

endmodule

// File: tb/tb_vga_fill_arbiter.sv
// tb/tb_vga_fill_arbiter.sv - directed vector bench for vga_fill_arbiter
// CPU-only vector table plus hand-written fill, clip, contention and reset sequences.
module tb_vga_fill_arbiter;

  logic        clock = 1'b0;
  logic        resetn;
  logic        cpu_wren;
  logic [18:0] cpu_addr;
  logic [23:0] cpu_data;
  logic        cpu_stall;
  logic        fill_start;
  logic [9:0]  fill_x0;
  logic [8:0]  fill_y0;
  logic [9:0]  fill_w;
  logic [8:0]  fill_h;
  logic [23:0] fill_color;
  logic        fill_busy;
  logic        fill_done;
  logic        vga_wren_enable;
  logic [18:0] vga_data_addr;
  logic [23:0] vga_data_write;

  vga_fill_arbiter dut (
    .clock(clock), .resetn(resetn),
    .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_stall(cpu_stall),
    .fill_start(fill_start), .fill_x0(fill_x0), .fill_y0(fill_y0), .fill_w(fill_w),
    .fill_h(fill_h), .fill_color(fill_color), .fill_busy(fill_busy), .fill_done(fill_done),
    .vga_wren_enable(vga_wren_enable), .vga_data_addr(vga_data_addr), .vga_data_write(vga_data_write)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wren;
    logic [18:0] addr;
    logic [23:0] data;
    logic        exp_wren;
    logic [18:0] exp_addr;
    logic [23:0] exp_data;
  } cpu_vec_t;

  cpu_vec_t    vecs[7];
  int          tests = 0;
  int          failed = 0;
  int          cyc = 0;
  int          n0, done_cnt, done_cyc, first_cyc, k;
  bit          done_on_wr, last_stall;
  logic [18:0] wa_q[$];
  logic [23:0] wd_q[$];
  logic        st_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic sample();
    last_stall = cpu_stall;
    st_q.push_back(cpu_stall);
    if (vga_wren_enable) begin
      if (wa_q.size() == 0) first_cyc = cyc;
      wa_q.push_back(vga_data_addr);
      wd_q.push_back(vga_data_write);
    end
    if (fill_done) begin
      done_cnt++;
      done_cyc   = cyc;
      done_on_wr = vga_wren_enable;
    end
  endtask

  task automatic step();
    @(negedge clock);
    sample();
    @(posedge clock);
    cyc++;
    #2;
  endtask

  task automatic clr();
    wa_q.delete();
    wd_q.delete();
    st_q.delete();
    done_cnt   = 0;
    done_cyc   = -1;
    first_cyc  = -1;
    done_on_wr = 0;
  endtask

  task automatic start_fill(input int x0, input int y0, input int w, input int h, input logic [23:0] c);
    clr();
    fill_x0 = 10'(x0); fill_y0 = 9'(y0); fill_w = 10'(w); fill_h = 9'(h); fill_color = c;
    fill_start = 1'b1;
    n0 = cyc;
    step();
    fill_start = 1'b0;
  endtask

  task automatic wait_fill(input string name);
    for (int i = 0; i < 3000 && fill_busy; i++) step();
    chk({name, "_idle"}, 32'(fill_busy), 32'd0);
    step();
    step();
  endtask

  // Reference: clipped row-major pixel list compared against the logged port writes.
  task automatic chk_rect(input string name, input int x0, input int y0, input int w, input int h,
                          input logic [23:0] c);
    int idx = 0;
    int xe = (x0 + w > 640) ? 640 : x0 + w;
    int ye = (y0 + h > 480) ? 480 : y0 + h;
    int n = (w == 0 || h == 0 || x0 >= 640 || y0 >= 480) ? 0 : (xe - x0) * (ye - y0);
    chk({name, "_count"}, 32'(wa_q.size()), 32'(n));
    for (int y = y0; y < ye && n > 0; y++)
      for (int x = x0; x < xe; x++) begin
        if (idx < wa_q.size()) begin
          chk($sformatf("%s_addr%0d", name, idx), 32'(wa_q[idx]), 32'(y * 640 + x));
          chk($sformatf("%s_data%0d", name, idx), 32'(wd_q[idx]), 32'(c));
        end
        idx++;
      end
    chk({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 19'd1000,   24'hFF0000, 1'b1, 19'd1000,   24'hFF0000};
    vecs[1] = '{1'b1, 19'd0,      24'h123456, 1'b1, 19'd0,      24'h123456};
    vecs[2] = '{1'b1, 19'd307199, 24'hABCDEF, 1'b1, 19'd307199, 24'hABCDEF};
    vecs[3] = '{1'b1, 19'd307200, 24'h111111, 1'b0, 19'd0,      24'h0};
    vecs[4] = '{1'b0, 19'd5,      24'h000000, 1'b0, 19'd0,      24'h0};
    vecs[5] = '{1'b1, 19'd524287, 24'h222222, 1'b0, 19'd0,      24'h0};
    vecs[6] = '{1'b1, 19'd2,      24'h000001, 1'b1, 19'd2,      24'h000001};

    resetn = 1'b0; cpu_wren = 1'b0; cpu_addr = '0; cpu_data = '0;
    fill_start = 1'b0; fill_x0 = '0; fill_y0 = '0; fill_w = '0; fill_h = '0; fill_color = '0;
    clr();
    step();
    chk("rst_wren", 32'(vga_wren_enable), 32'd0);
    chk("rst_addr", 32'(vga_data_addr), 32'd0);
    chk("rst_data", 32'(vga_data_write), 32'd0);
    chk("rst_busy", 32'(fill_busy), 32'd0);
    chk("rst_done", 32'(fill_done), 32'd0);
    resetn = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      cpu_wren = vecs[i].wren; cpu_addr = vecs[i].addr; cpu_data = vecs[i].data;
      #1;
      chk($sformatf("cpu%0d_stall", i), 32'(cpu_stall), 32'd0);
      step();
      chk($sformatf("cpu%0d_wren", i), 32'(vga_wren_enable), 32'(vecs[i].exp_wren));
      if (vecs[i].exp_wren) begin
        chk($sformatf("cpu%0d_addr", i), 32'(vga_data_addr), 32'(vecs[i].exp_addr));
        chk($sformatf("cpu%0d_data", i), 32'(vga_data_write), 32'(vecs[i].exp_data));
      end
    end
    cpu_wren = 1'b0;
    step();

    start_fill(10, 2, 3, 2, 24'h00FF00);
    wait_fill("fill");
    chk_rect("fill", 10, 2, 3, 2, 24'h00FF00);
    chk("fill_first_addr", 32'(wa_q.size() > 0 ? wa_q[0] : 19'd0), 32'd1290);
    chk("fill_last_addr", 32'(wa_q.size() > 5 ? wa_q[5] : 19'd0), 32'd1932);
    chk("fill_first_lat", 32'(first_cyc - n0), 32'd3);
    chk("fill_done_lat", 32'(done_cyc - n0), 32'd8);
    chk("fill_done_on_wr", 32'(done_on_wr), 32'd1);

    start_fill(638, 479, 5, 5, 24'h0000FF);
    wait_fill("clip");
    chk_rect("clip", 638, 479, 5, 5, 24'h0000FF);
    chk("clip_a0", 32'(wa_q.size() > 0 ? wa_q[0] : 19'd0), 32'd307198);
    chk("clip_a1", 32'(wa_q.size() > 1 ? wa_q[1] : 19'd0), 32'd307199);

    start_fill(700, 0, 4, 4, 24'h0000FF);
    wait_fill("xout");
    chk("xout_writes", 32'(wa_q.size()), 32'd0);
    chk("xout_done_lat", 32'(done_cyc - n0), 32'd2);
    chk("xout_done_cnt", 32'(done_cnt), 32'd1);

    start_fill(5, 5, 0, 3, 24'h0000FF);
    wait_fill("w0");
    chk("w0_writes", 32'(wa_q.size()), 32'd0);
    chk("w0_done_cnt", 32'(done_cnt), 32'd1);

    // Restart attempt while RUN must not disturb the fill in flight.
    start_fill(10, 2, 3, 2, 24'h00FF00);
    step();
    fill_x0 = 10'd0; fill_y0 = 9'd0; fill_w = 10'd1; fill_h = 9'd1; fill_color = 24'hABCDEF;
    fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    wait_fill("restart");
    chk_rect("restart", 10, 2, 3, 2, 24'h00FF00);

    start_fill(0, 0, 4, 1, 24'h0000FF);
    step();
    clr();
    cpu_wren = 1'b1; cpu_addr = 19'd100; cpu_data = 24'h000C00;
    k = 0;
    for (int i = 0; i < 40 && k < 5; i++) begin
      step();
      if (!last_stall) begin
        k++;
        cpu_addr = 19'(100 + k);
        cpu_data = 24'(24'h000C00 + k);
      end
    end
    cpu_wren = 1'b0;
    chk("cont_cpu_accepts", 32'(k), 32'd5);
    wait_fill("cont");
    chk("cont_count", 32'(wa_q.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < wa_q.size()) begin
        chk($sformatf("cont_addr%0d", i), 32'(wa_q[i]), (i % 2 == 0) ? 32'(100 + i / 2) : 32'(i / 2));
        chk($sformatf("cont_data%0d", i), 32'(wd_q[i]),
            (i % 2 == 0) ? 32'(24'h000C00 + i / 2) : 32'h0000FF);
      end
      if (i < st_q.size())
        chk($sformatf("cont_stall%0d", i), 32'(st_q[i]), 32'(i % 2));
    end
    chk("cont_done_cnt", 32'(done_cnt), 32'd1);

    start_fill(10, 2, 3, 2, 24'h00FF00);
    for (int i = 0; i < 40 && wa_q.size() < 2; i++) step();
    resetn = 1'b0;
    #1;
    chk("mid_rst_wren", 32'(vga_wren_enable), 32'd0);
    chk("mid_rst_addr", 32'(vga_data_addr), 32'd0);
    chk("mid_rst_data", 32'(vga_data_write), 32'd0);
    chk("mid_rst_busy", 32'(fill_busy), 32'd0);
    chk("mid_rst_done", 32'(fill_done), 32'd0);
    clr();
    step();
    step();
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("post_rst_writes", 32'(wa_q.size()), 32'd0);
    chk("post_rst_busy", 32'(fill_busy), 32'd0);
    start_fill(10, 2, 3, 2, 24'h00FF00);
    wait_fill("after_rst");
    chk_rect("after_rst", 10, 2, 3, 2, 24'h00FF00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
